gate_vector_checker: RTL

Self-checking stimulus source for the team's 4-input gate-reduction block. It drives all 16 values of a 4-bit input vector in ascending order and waits a programmable settle time per vector. It then samples the block's six gate outputs, compares them with internally computed expected values, and reports a pass/fail summary. It sits on the FPGA test wrapper between board switches/LEDs and the gate block under test.

---
 rtl/gate_chk_pkg.sv | 26 ++
 rtl/gate_expect_model.sv | 24 ++
 rtl/gate_vector_checker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
// COMBO_CHECK_EN adds the combo-gate output as mask bit 6.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int X1_BIT = 0;
    localparam int Y1_BIT = 1;
    localparam int Z1_BIT = 2;
    localparam int X2_BIT = 3;
    localparam int Y2_BIT = 4;
    localparam int Z2_BIT = 5;

`ifdef COMBO_CHECK_EN
    localparam int O_BIT  = 6;
    localparam int MASK_W = 7;
`else
    localparam int MASK_W = 6;
`endif

endpackage

// File: rtl/gate_expect_model.sv
// Combinational reference for the gate block outputs, packed in fail_mask bit order.
// COMBO_CHECK_EN adds the combo-gate expectation at bit O_BIT.
module gate_expect_model
    import gate_chk_pkg::*;
(
    input  logic [3:0]        i_v,
    output logic [MASK_W-1:0] o_exp
);

    // x1 reduces all four bits; the remaining gates only see v[3:1].
    always_comb begin
        o_exp         = '0;
        o_exp[X1_BIT] = &i_v[3:0];
        o_exp[Y1_BIT] = |i_v[3:1];
        o_exp[Z1_BIT] = ^i_v[3:1];
        o_exp[X2_BIT] = ~&i_v[3:1];
        o_exp[Y2_BIT] = ~|i_v[3:1];
        o_exp[Z2_BIT] = ~^i_v[3:1];
`ifdef COMBO_CHECK_EN
        o_exp[O_BIT]  = ~((i_v[0] & i_v[1]) | (i_v[2] ^ i_v[3]));
`endif
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps a 4-bit vector through the gate block, compares its outputs and keeps a summary.
// Optional: COMBO_CHECK_EN adds the dut_o input and widens fail_mask to 7 bits.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic [3:0]        a_out,
    input  logic              dut_x1,
    input  logic              dut_y1,
    input  logic              dut_z1,
    input  logic              dut_x2,
    input  logic              dut_y2,
    input  logic              dut_z2,
`ifdef COMBO_CHECK_EN
    input  logic              dut_o,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_count,
    output logic [MASK_W-1:0] fail_mask,
    output logic [3:0]        first_fail_vec,
    output logic              first_fail_valid
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_e              r_state, w_state_nxt;
    logic [3:0]          r_a_out, w_a_out_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [4:0]          r_err_count, w_err_count_nxt;
    logic [MASK_W-1:0]   r_fail_mask, w_fail_mask_nxt;
    logic [3:0]          r_ffv, w_ffv_nxt;
    logic                r_ffvalid, w_ffvalid_nxt;
    logic                r_busy, r_done, r_pass;
    logic [MASK_W-1:0]   w_exp, w_obs, w_mism;

    gate_expect_model u_expect (
        .i_v   (r_a_out),
        .o_exp (w_exp)
    );

    always_comb begin
        w_obs         = '0;
        w_obs[X1_BIT] = dut_x1;
        w_obs[Y1_BIT] = dut_y1;
        w_obs[Z1_BIT] = dut_z1;
        w_obs[X2_BIT] = dut_x2;
        w_obs[Y2_BIT] = dut_y2;
        w_obs[Z2_BIT] = dut_z2;
`ifdef COMBO_CHECK_EN
        w_obs[O_BIT]  = dut_o;
`endif
    end

    assign w_mism = w_exp ^ w_obs;

    // NOTE: every next-state value gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_out_nxt     = r_a_out;
        w_cnt_nxt       = r_cnt;
        w_err_count_nxt = r_err_count;
        w_fail_mask_nxt = r_fail_mask;
        w_ffv_nxt       = r_ffv;
        w_ffvalid_nxt   = r_ffvalid;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt     = SETTLE;
                    w_a_out_nxt     = '0;
                    w_cnt_nxt       = SETTLE_LOAD;
                    w_err_count_nxt = '0;
                    w_fail_mask_nxt = '0;
                    w_ffv_nxt       = '0;
                    w_ffvalid_nxt   = 1'b0;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) w_state_nxt = SAMPLE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            SAMPLE: begin
                if (w_mism != '0) begin
                    w_err_count_nxt = r_err_count + 5'd1;
                    w_fail_mask_nxt = r_fail_mask | w_mism;
                    if (!r_ffvalid) begin
                        w_ffv_nxt     = r_a_out;
                        w_ffvalid_nxt = 1'b1;
                    end
                end
                // Vector 15 is terminal: a_out holds there for the DONE readout.
                if (r_a_out == 4'd15) begin
                    w_state_nxt = DONE;
                end else begin
                    w_a_out_nxt = r_a_out + 4'd1;
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_state_nxt = SETTLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_a_out     <= '0;
            r_cnt       <= '0;
            r_err_count <= '0;
            r_fail_mask <= '0;
            r_ffv       <= '0;
            r_ffvalid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a_out     <= w_a_out_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_count <= w_err_count_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_ffv       <= w_ffv_nxt;
            r_ffvalid   <= w_ffvalid_nxt;
            r_busy      <= (w_state_nxt == SETTLE) || (w_state_nxt == SAMPLE);
            r_done      <= (w_state_nxt == DONE);
            r_pass      <= (w_state_nxt == DONE) && (w_err_count_nxt == 5'd0);
        end
    end

    assign a_out            = r_a_out;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign fail_mask        = r_fail_mask;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvalid;

endmodule
